conv1_tile_scheduler: RTL and testbench

- Sequences the conv1 GEMM engine over output tiles: one tile per engine run, ordered by row band then output-channel group.
- Presents each tile's coordinates with a one-cycle start pulse and waits for the engine's done.
- Hands each finished tile to the output drain through a valid/ready handshake before it issues the next tile.
- Sits between the AXIS wrapper FSM (start/abort) and conv1_gemm_top (tile start/done).

---
 rtl/backbone_pkg.sv | 31 +++
 rtl/conv1_tile_scheduler_coord_gen.sv | 83 ++++++++
 rtl/conv1_tile_scheduler.sv | 176 +++++++++++++++++
 tb/tb_conv1_tile_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backbone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : backbone_pkg
// Description : Shared types and constants for the conv1 backbone blocks.
//               Holds the tile-scheduler state encoding, the default conv1
//               tile geometry and a helper that derives the tile count.
// Revision    : 1.0 - initial release
// ============================================================================
package backbone_pkg;

    // Tile scheduler states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    // Default conv1 tile geometry.
    localparam int CONV1_COUT_TILE = 16;
    localparam int CONV1_ROW_TILE  = 8;

    // Number of output tiles in one conv1 job (CONV1_NTILES).
    function automatic int conv1_ntiles(input int cout, input int h_out,
                                        input int cout_tile, input int row_tile);
        return (cout / cout_tile) * (h_out / row_tile);
    endfunction

endpackage : backbone_pkg
`default_nettype wire

// File: rtl/conv1_tile_scheduler_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv1_tile_coord_gen
// Description : Tile coordinate generator for the conv1 tile scheduler.
//               Walks output-channel groups (inner) within row bands (outer)
//               and counts drained tiles.
// Ports       : clk, rst_n     - clock, async active-low reset
//               clear          - restart at tile (0,0), tile_idx = 0
//               advance        - current tile drained: count it, step coords
//               co_base        - first output channel of the current tile
//               oh_base        - first output row of the current tile
//               tile_idx       - tiles drained in this job
//               is_last        - current tile is the final tile of the job
// Revision    : 1.0 - initial release
// ============================================================================
module conv1_tile_coord_gen
    import backbone_pkg::*;
#(
    parameter int COUT      = 64,
    parameter int H_OUT     = 56,
    parameter int COUT_TILE = CONV1_COUT_TILE,
    parameter int ROW_TILE  = CONV1_ROW_TILE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                advance,
    output logic [$clog2(COUT)-1:0]             co_base,
    output logic [$clog2(H_OUT)-1:0]            oh_base,
    output logic [$clog2(conv1_ntiles(COUT, H_OUT, COUT_TILE, ROW_TILE)+1)-1:0] tile_idx,
    output logic                                is_last
);

    localparam int NTILES = conv1_ntiles(COUT, H_OUT, COUT_TILE, ROW_TILE);
    localparam int CO_W   = $clog2(COUT);
    localparam int OH_W   = $clog2(H_OUT);
    localparam int IDX_W  = $clog2(NTILES + 1);

    localparam logic [CO_W-1:0]  c_co_step = CO_W'(COUT_TILE);
    localparam logic [CO_W-1:0]  c_co_last = CO_W'(COUT - COUT_TILE);
    localparam logic [OH_W-1:0]  c_oh_step = OH_W'(ROW_TILE);
    localparam logic [OH_W-1:0]  c_oh_last = OH_W'(H_OUT - ROW_TILE);

    logic [CO_W-1:0]  r_co;
    logic [OH_W-1:0]  r_oh;
    logic [IDX_W-1:0] r_idx;
    logic             w_co_wrap;

    // Wrap is detected by value rather than by overflow so that COUT need
    // not be a power of two.
    assign w_co_wrap = (r_co == c_co_last);
    assign is_last   = w_co_wrap && (r_oh == c_oh_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_co  <= '0;
            r_oh  <= '0;
            r_idx <= '0;
        end else if (clear) begin
            r_co  <= '0;
            r_oh  <= '0;
            r_idx <= '0;
        end else if (advance) begin
            r_idx <= r_idx + IDX_W'(1);
            // The final tile keeps its coordinates so they remain readable
            // after the job completes.
            if (!is_last) begin
                if (w_co_wrap) begin
                    r_co <= '0;
                    r_oh <= r_oh + c_oh_step;
                end else begin
                    r_co <= r_co + c_co_step;
                end
            end
        end
    end

    assign co_base  = r_co;
    assign oh_base  = r_oh;
    assign tile_idx = r_idx;

endmodule : conv1_tile_coord_gen
`default_nettype wire

// File: rtl/conv1_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv1_tile_scheduler
// Description : Sequences the conv1 GEMM engine over output tiles, one tile
//               per engine run, row band outer / channel group inner. Each
//               finished tile is handed to the output drain before the next
//               tile is issued.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, abort        - job control from the AXIS wrapper FSM
//               busy, done          - job status (done is sticky)
//               tile_start          - one-cycle pulse to the engine
//               tile_co_base/oh_base- coordinates of the current tile
//               tile_done           - engine completion pulse
//               drain_valid/ready   - finished-tile handshake to the drain
//               drain_last          - final tile of the job
//               tile_idx            - tiles completed and drained this job
//               perf_busy_cyc       - cycles spent busy (CONV1_SCHED_PERF_EN)
//               perf_stall_cyc      - drain stall cycles (CONV1_SCHED_PERF_EN)
// Options     : define CONV1_SCHED_PERF_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module conv1_tile_scheduler
    import backbone_pkg::*;
#(
    parameter int COUT      = 64,
    parameter int H_OUT     = 56,
    parameter int COUT_TILE = CONV1_COUT_TILE,
    parameter int ROW_TILE  = CONV1_ROW_TILE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    output logic                                busy,
    output logic                                done,
    output logic                                tile_start,
    output logic [$clog2(COUT)-1:0]             tile_co_base,
    output logic [$clog2(H_OUT)-1:0]            tile_oh_base,
    input  logic                                tile_done,
    output logic                                drain_valid,
    input  logic                                drain_ready,
    output logic                                drain_last,
`ifdef CONV1_SCHED_PERF_EN
    output logic [$clog2(conv1_ntiles(COUT, H_OUT, COUT_TILE, ROW_TILE)+1)-1:0] tile_idx,
    output logic [31:0]                         perf_busy_cyc,
    output logic [31:0]                         perf_stall_cyc
`else
    output logic [$clog2(conv1_ntiles(COUT, H_OUT, COUT_TILE, ROW_TILE)+1)-1:0] tile_idx
`endif
);

    sched_state_t r_state;
    logic         r_busy;
    logic         r_done;
    logic         r_tile_start;
    logic         r_drain_valid;
    logic         r_drain_last;

    logic         w_active;
    logic         w_clear;
    logic         w_advance;
    logic         w_is_last;

    assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                       (r_state == S_DRAIN);
    assign w_clear   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    // Abort outranks the drain handshake, so an aborted tile is not counted.
    assign w_advance = (r_state == S_DRAIN) && drain_ready && !abort;

    conv1_tile_coord_gen #(
        .COUT      (COUT),
        .H_OUT     (H_OUT),
        .COUT_TILE (COUT_TILE),
        .ROW_TILE  (ROW_TILE)
    ) u_coord_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .advance  (w_advance),
        .co_base  (tile_co_base),
        .oh_base  (tile_oh_base),
        .tile_idx (tile_idx),
        .is_last  (w_is_last)
    );

    // busy and tile_start are registered decodes of the state held during
    // the previous cycle, so both rise one cycle after S_ISSUE is entered.
    // drain_valid/drain_last are set on the same edge that enters S_DRAIN,
    // which keeps the handshake aligned with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tile_start  <= 1'b0;
            r_drain_valid <= 1'b0;
            r_drain_last  <= 1'b0;
        end else begin
            r_tile_start <= 1'b0;
            r_busy       <= w_active;
            if (w_active && abort) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_drain_valid <= 1'b0;
                r_drain_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_done  <= 1'b0;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_tile_start <= 1'b1;
                        r_state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (tile_done) begin
                            r_drain_valid <= 1'b1;
                            r_drain_last  <= w_is_last;
                            r_state       <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_ready) begin
                            r_drain_valid <= 1'b0;
                            r_drain_last  <= 1'b0;
                            if (r_drain_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign tile_start  = r_tile_start;
    assign drain_valid = r_drain_valid;
    assign drain_last  = r_drain_last;

`ifdef CONV1_SCHED_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    // Counters saturate rather than wrap; outside an active job they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_clear) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_active && (r_perf_busy != '1)) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if ((r_state == S_DRAIN) && !drain_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`endif

endmodule : conv1_tile_scheduler
`default_nettype wire

// File: tb/tb_conv1_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv1_tile_scheduler
// Description : Directed self-checking bench for conv1_tile_scheduler.
//               An engine model answers each tile_start with tile_done five
//               cycles later; a monitor checks tile order and drain_last.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1_tile_scheduler;

    localparam int NT = 28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        eng_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        drain_ready = 1'b1;
    logic        tile_done;
    logic        busy, done, tile_start, drain_valid, drain_last;
    logic [5:0]  co, oh;
    logic [4:0]  idx;
`ifdef CONV1_SCHED_PERF_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_drain  = 0;
    int k_base   = 0;
    int d_base   = 0;

    assign tile_done = eng_done | spur_done;

    always #5 clk = ~clk;

    conv1_tile_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .tile_start     (tile_start),
        .tile_co_base   (co),
        .tile_oh_base   (oh),
        .tile_done      (tile_done),
        .drain_valid    (drain_valid),
        .drain_ready    (drain_ready),
        .drain_last     (drain_last),
`ifdef CONV1_SCHED_PERF_EN
        .tile_idx       (idx),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
`else
        .tile_idx       (idx)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Engine: tile_done is sampled by the scheduler five edges after the
    // edge that raised tile_start.
    task automatic engine_model();
        forever begin
            @(negedge clk);
            if (tile_start) begin
                repeat (4) @(negedge clk);
                eng_done = 1'b1;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    endtask

    // Expected order: channel group inner (0,16,32,48), row band outer.
    task automatic monitor();
        int j;
        forever begin
            @(negedge clk);
            #1;
            if (tile_start) begin
                j = n_start - k_base;
                check("tile_co", 32'(co), (j % 4) * 16);
                check("tile_oh", 32'(oh), (j / 4) * 8);
                n_start++;
            end
            if (drain_valid && drain_ready) begin
                check("drain_last", 32'(drain_last), 32'((n_drain - d_base) == NT - 1));
                n_drain++;
            end
        end
    endtask

    task automatic begin_job();
        k_base = n_start;
        d_base = n_drain;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 600) begin
            tick();
            t++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic wait_starts(input int n, input string tag);
        int t;
        t = 0;
        while ((n_start - k_base) < n && t < 600) begin
            tick();
            t++;
        end
        check(tag, 32'((n_start - k_base) >= n), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_tstart"}, 32'(tile_start), 0);
        check({tag, "_dvalid"}, 32'(drain_valid), 0);
        check({tag, "_dlast"}, 32'(drain_last), 0);
        check({tag, "_co"}, 32'(co), 0);
        check({tag, "_oh"}, 32'(oh), 0);
        check({tag, "_idx"}, 32'(idx), 0);
    endtask

    initial begin
        int  t;
        bit  hit;

        fork
            engine_model();
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Spurious tile_done in S_IDLE
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        check("idle_spur_busy", 32'(busy), 0);
        check("idle_spur_tstart", 32'(tile_start), 0);

        // Job 1: latency then full run
        k_base = n_start;
        d_base = n_drain;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("lat_n_tstart", 32'(tile_start), 0);
        check("lat_n_busy", 32'(busy), 0);
        tick();
        check("lat_n1_tstart", 32'(tile_start), 1);
        check("lat_n1_busy", 32'(busy), 1);
        tick();
        check("lat_n2_tstart", 32'(tile_start), 0);
        check("lat_n2_busy", 32'(busy), 1);
        wait_done("job1_done");
        check("job1_idx", 32'(idx), NT);
        check("job1_starts", n_start - k_base, NT);
        check("job1_drains", n_drain - d_base, NT);
        check("job1_last_co", 32'(co), 48);
        check("job1_last_oh", 32'(oh), 48);
        repeat (2) tick();
        check("job1_busy_low", 32'(busy), 0);
        check("job1_done_sticky", 32'(done), 1);

        // Job 2: backpressure on tile (32,0) plus spurious inputs
        begin_job();
        check("job2_done_clr", 32'(done), 0);
        check("job2_idx_clr", 32'(idx), 0);
        hit = 1'b0;
        for (t = 0; t < 200 && !hit; t++) begin
            tick();
            hit = tile_start && (co == 6'd32) && (oh == 6'd0);
        end
        check("bp_tile3_seen", 32'(hit), 1);
        drain_ready = 1'b0;
        t = 0;
        while (!drain_valid && t < 50) begin
            tick();
            t++;
        end
        check("bp_valid_rise", 32'(drain_valid), 1);
        for (int i = 0; i < 7; i++) begin
            check("bp_valid", 32'(drain_valid), 1);
            check("bp_co", 32'(co), 32);
            check("bp_oh", 32'(oh), 0);
            check("bp_no_tstart", 32'(tile_start), 0);
            spur_done = (i == 2);
            start     = (i == 4);
            tick();
        end
        check("bp_valid_end", 32'(drain_valid), 1);
        check("bp_idx_hold", 32'(idx), 2);
        drain_ready = 1'b1;
        tick();
        check("bp_handshake", 32'(drain_valid), 0);
        check("bp_idx_inc", 32'(idx), 3);
        wait_done("job2_done");
        check("job2_idx", 32'(idx), NT);
        check("job2_starts", n_start - k_base, NT);
`ifdef CONV1_SCHED_PERF_EN
        check("perf_stall", perf_stall_cyc, 7);
`endif

        // abort in S_DONE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("done_abort_done", 32'(done), 1);
        check("done_abort_idx", 32'(idx), NT);

        // Job 3: abort together with tile_done of tile 10
        begin_job();
        wait_starts(10, "abort_reach_t10");
        hit = 1'b0;
        for (t = 0; t < 50 && !hit; t++) begin
            @(negedge clk);
            #1;
            hit = eng_done;
        end
        check("abort_eng_done_seen", 32'(hit), 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_tstart", 32'(tile_start), 0);
        check("abort_dvalid", 32'(drain_valid), 0);
        check("abort_done", 32'(done), 0);
        check("abort_idx", 32'(idx), 9);
        repeat (8) tick();
        check("abort_dvalid_later", 32'(drain_valid), 0);
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_drains", n_drain - d_base, 9);

        // Job 4: restart at (0,0), then async reset during S_WAIT
        begin_job();
        check("restart_idx", 32'(idx), 0);
        check("restart_co", 32'(co), 0);
        check("restart_oh", 32'(oh), 0);
        wait_starts(5, "rst_reach_t5");
        tick();
        tick();
        check("rst_pre_busy", 32'(busy), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();

        // Job 5: full run after reset
        begin_job();
        wait_done("job5_done");
        check("job5_idx", 32'(idx), NT);
        check("job5_starts", n_start - k_base, NT);
        check("job5_drains", n_drain - d_base, NT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_conv1_tile_scheduler
`default_nettype wire
